// File: rtl/core_ctrl_seq.sv
// Instruction sequencer for one kij pass of core: weight fetch/load, activation fetch/execute,
// array drain and psum write. Drives core inst and the shared act/weight SRAM read port.
module core_ctrl_seq #(
   parameter int unsigned Row      = 8,
   parameter int unsigned Col      = 8,
   parameter int unsigned LenNij   = 16,
   parameter int unsigned AddrBw   = 11,
   parameter int unsigned ActBase  = 0,
   parameter int unsigned GapCyc   = 5,
   parameter int unsigned LoadWait = 20,
   parameter int unsigned DrainCyc = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [AddrBw-1:0] wgt_base,
   output logic              busy,
   output logic              done,
   output logic [6:0]        inst,
   output logic              cen_act_wgt,
   output logic              wen_act_wgt,
   output logic [AddrBw-1:0] addr_act_wgt
);

   localparam int unsigned IdxLoad    = 0;
   localparam int unsigned IdxExec    = 1;
   localparam int unsigned IdxL0Wr    = 2;
   localparam int unsigned IdxL0Rd    = 3;
   localparam int unsigned IdxMemWrite = 6;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Counter must hold the longest phase; Row+Col bounds any array-depth based setting.
   localparam int unsigned MaxLen = max2(max2(max2(Col + 1, LenNij + 1), max2(GapCyc, LoadWait)),
                                         max2(DrainCyc, Row + Col));
   localparam int unsigned CntW   = $clog2(MaxLen + 1);

   typedef enum logic [3:0] {
      StIdle, StWL0Wr, StWGap, StWLoad, StLWait, StAL0Wr, StAGap, StAExec, StDrain, StPsumWr,
      StDone
   } state_e;

   function automatic state_e succ(input state_e s);
      case (s)
         StIdle:   return StWL0Wr;
         StWL0Wr:  return StWGap;
         StWGap:   return StWLoad;
         StWLoad:  return StLWait;
         StLWait:  return StAL0Wr;
         StAL0Wr:  return StAGap;
         StAGap:   return StAExec;
         StAExec:  return StDrain;
         StDrain:  return StPsumWr;
         StPsumWr: return StDone;
         default:  return StIdle;
      endcase
   endfunction

   function automatic int unsigned phase_len(input state_e s);
      case (s)
         StWL0Wr:  return Col + 1;
         StWGap:   return GapCyc;
         StWLoad:  return Col;
         StLWait:  return LoadWait;
         StAL0Wr:  return LenNij + 1;
         StAGap:   return GapCyc;
         StAExec:  return LenNij;
         StDrain:  return DrainCyc;
         StPsumWr: return LenNij;
         default:  return 1;
      endcase
   endfunction

   // Successor with zero-length phases skipped.
   function automatic state_e next_live(input state_e s);
      state_e n;
      n = succ(s);
      for (int i = 0; i < 10; i++) begin
         if (phase_len(n) == 0) n = succ(n);
      end
      return n;
   endfunction

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [AddrBw-1:0] base_q, base_d;

   logic [6:0]        inst_d;
   logic              cen_d, busy_d, done_d;
   logic [AddrBw-1:0] addr_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      if (state_q == StIdle) begin
         if (start) begin
            base_d  = wgt_base;
            state_d = StWL0Wr;
            cnt_d   = CntW'(phase_len(StWL0Wr) - 1);
         end
      end else if (cnt_q == '0) begin
         state_d = next_live(state_q);
         cnt_d   = CntW'(phase_len(state_d) - 1);
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      inst_d = '0;
      cen_d  = 1'b1;
      addr_d = '0;
      done_d = 1'b0;
      busy_d = (state_d != StIdle);
      case (state_d)
         StWL0Wr: begin
            // cnt counts down from Col, so word index is Col - cnt; last cycle only drains
            if (cnt_d != '0) begin
               cen_d  = 1'b0;
               addr_d = base_d + AddrBw'(Col - 32'(cnt_d));
            end
            inst_d[IdxL0Wr] = (cnt_d != CntW'(Col));
         end
         StWLoad: begin
            inst_d[IdxL0Rd] = 1'b1;
            inst_d[IdxLoad] = 1'b1;
         end
         StAL0Wr: begin
            if (cnt_d != '0) begin
               cen_d  = 1'b0;
               addr_d = AddrBw'(ActBase + LenNij - 32'(cnt_d));
            end
            inst_d[IdxL0Wr] = (cnt_d != CntW'(LenNij));
         end
         StAExec: begin
            inst_d[IdxL0Rd] = 1'b1;
            inst_d[IdxExec] = 1'b1;
         end
         StPsumWr: inst_d[IdxMemWrite] = 1'b1;
         StDone:   done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         base_q       <= '0;
         inst         <= '0;
         cen_act_wgt  <= 1'b1;
         wen_act_wgt  <= 1'b1;
         addr_act_wgt <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         base_q       <= base_d;
         inst         <= inst_d;
         cen_act_wgt  <= cen_d;
         wen_act_wgt  <= 1'b1;
         addr_act_wgt <= addr_d;
         busy         <= busy_d;
         done         <= done_d;
      end
   end

endmodule

// File: tb/tb_core_ctrl_seq.sv
// Bench for core_ctrl_seq: directed scenarios plus random start/reset traffic, every cycle
// scored against a phase-table model built from the pass timeline.
module tb_core_ctrl_seq;

   localparam int AW    = 11;
   localparam int COL   = 8;
   localparam int LEN   = 16;
   localparam int GAP   = 5;
   localparam int LWAIT = 20;
   localparam int DRAIN = 32;
   localparam int PASS  = (COL + 1) + GAP + COL + LWAIT + (LEN + 1) + GAP + LEN + DRAIN + LEN;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] wgt_base = '0;
   logic          busy, done, cen_act_wgt, wen_act_wgt;
   logic [6:0]    inst;
   logic [AW-1:0] addr_act_wgt;

   always #5 clk = ~clk;

   core_ctrl_seq dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .wgt_base     (wgt_base),
      .busy         (busy),
      .done         (done),
      .inst         (inst),
      .cen_act_wgt  (cen_act_wgt),
      .wen_act_wgt  (wen_act_wgt),
      .addr_act_wgt (addr_act_wgt)
   );

   int total = 0;
   int bad   = 0;

   // Model: m_act is high while a pass runs, m_t is the cycle index within it (PASS = done).
   bit            m_act = 1'b0;
   int            m_t   = 0;
   logic [AW-1:0] m_base = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic exp_out(output logic [6:0] ei, output logic ec, output logic [AW-1:0] ea,
                          output logic eb, output logic ed);
      int lens[9];
      int p, k;
      lens = '{COL + 1, GAP, COL, LWAIT, LEN + 1, GAP, LEN, DRAIN, LEN};
      ei = '0; ec = 1'b1; ea = '0; eb = m_act; ed = 1'b0;
      if (m_act) begin
         p = 0;
         k = m_t;
         while (p < 9 && k >= lens[p]) begin
            k -= lens[p];
            p++;
         end
         case (p)
            0: begin
               if (k < COL) begin ec = 1'b0; ea = AW'(m_base + k); end
               ei[2] = (k >= 1);
            end
            2: begin ei[3] = 1'b1; ei[0] = 1'b1; end
            4: begin
               if (k < LEN) begin ec = 1'b0; ea = AW'(k); end
               ei[2] = (k >= 1);
            end
            6: begin ei[3] = 1'b1; ei[1] = 1'b1; end
            8: ei[6] = 1'b1;
            9: ed = 1'b1;
            default: ;
         endcase
      end
   endtask

   // Drive one cycle of inputs, advance the model, then score all outputs after the edge.
   task automatic step(input logic rst, input logic st, input logic [AW-1:0] wb);
      logic [6:0] ei;
      logic ec, eb, ed;
      logic [AW-1:0] ea;
      @(negedge clk);
      reset = rst; start = st; wgt_base = wb;
      if (rst) m_act = 1'b0;
      else if (!m_act) begin
         if (st) begin m_act = 1'b1; m_t = 0; m_base = wb; end
      end else if (m_t == PASS) m_act = 1'b0;
      else m_t++;
      @(posedge clk);
      #1;
      exp_out(ei, ec, ea, eb, ed);
      check("inst", 32'(inst), 32'(ei));
      check("cen", 32'(cen_act_wgt), 32'(ec));
      check("wen", 32'(wen_act_wgt), 32'd1);
      check("addr", 32'(addr_act_wgt), 32'(ea));
      check("busy", 32'(busy), 32'(eb));
      check("done", 32'(done), 32'(ed));
   endtask

   // Start a pass and measure edges until done is seen (bounded).
   task automatic run_pass(input logic [AW-1:0] wb, input bit noisy_start);
      int n;
      step(1'b0, 1'b1, wb);
      n = 0;
      while (n < 300 && done !== 1'b1) begin
         step(1'b0, noisy_start ? 1'($urandom_range(0, 1)) & (n < PASS - 1) : 1'b0,
              AW'($urandom_range(0, 2047)));
         n++;
      end
      check("done_lat", 32'(n), 32'(PASS));
   endtask

   initial begin
      // reset then quiet idle
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0);

      // baseline pass with busy-time start noise
      run_pass(AW'(1024), 1'b1);
      step(1'b0, 1'b0, '0);

      // top-of-memory bases, second one wraps
      run_pass(AW'(2040), 1'b0);
      step(1'b0, 1'b0, '0);
      run_pass(AW'(2044), 1'b0);
      step(1'b0, 1'b0, '0);

      // start held high: back-to-back passes
      for (int i = 0; i < 2 * (PASS + 2) + 3; i++) step(1'b0, 1'b1, AW'(100 + i));
      while (busy === 1'b1 && m_act) step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);

      // abort mid-execute, then a clean full pass
      step(1'b0, 1'b1, AW'(512));
      for (int i = 0; i < 69; i++) step(1'b0, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
      run_pass(AW'(7), 1'b0);
      step(1'b0, 1'b0, '0);

      // random traffic with rare resets
      for (int i = 0; i < 900; i++)
         step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) == 0),
              AW'($urandom_range(0, 2047)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
